// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the writeback arbiter and its sibling blocks.
package regfile_pkg;

   localparam int DATA_W       = 16;
   localparam int ADDR_W       = 4;
   localparam int NUM_REGS     = 1 << ADDR_W;
   localparam int NUM_RD_PORTS = 3;

   typedef logic [ADDR_W-1:0] regIdx_t;
   typedef logic [DATA_W-1:0] regData_t;

   localparam regIdx_t  REG_SP       = 4'd13;
   localparam regIdx_t  REG_LR       = 4'd14;
   localparam regIdx_t  REG_PC       = 4'd15;
   localparam regData_t SP_RESET_VAL = 16'h0080;

   // One-hot mask for a register index, handy for scoreboard-style bit vectors.
   function automatic logic [NUM_REGS-1:0] regMask(input regIdx_t idx);
      logic [NUM_REGS-1:0] m;
      m      = '0;
      m[idx] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin request arbiter: one-hot grant plus the pointer to use after that grant.
// Building with WB_ARB_FIXED_PRIO_EN switches to lowest-index-wins with a frozen pointer.
module rr_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] reqVec,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   grantIdx,
   output logic               anyGrant,
   output logic [PTR_W-1:0]   nextPtr
);

`ifdef WB_ARB_FIXED_PRIO_EN
   always_comb begin
      grant    = '0;
      grantIdx = '0;
      anyGrant = 1'b0;
      nextPtr  = ptr;
      // Scan downward so the lowest valid index is the last one written.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (reqVec[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            grantIdx = PTR_W'(i);
            anyGrant = 1'b1;
         end
      end
   end
`else
   always_comb begin
      int idx;
      grant    = '0;
      grantIdx = '0;
      anyGrant = 1'b0;
      nextPtr  = ptr;
      idx      = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!anyGrant && reqVec[idx]) begin
            grant[idx] = 1'b1;
            grantIdx   = PTR_W'(idx);
            anyGrant   = 1'b1;
            nextPtr    = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
         end
      end
   end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port, with a pending-write scoreboard.
// Optional build macro: WB_ARB_FIXED_PRIO_EN (fixed lowest-index priority instead of round-robin).
module regfile_wb_arbiter #(
   parameter int NUM_REQ  = 3,
   parameter int DATA_W   = regfile_pkg::DATA_W,
   parameter int ADDR_W   = regfile_pkg::ADDR_W,
   parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
   input  logic                                    clock,
   input  logic                                    rst,
   input  logic [NUM_REQ-1:0]                      req_valid,
   output logic [NUM_REQ-1:0]                      req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]               req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]               req_data,
   output logic                                    rf_we,
   output logic [ADDR_W-1:0]                       rf_wr_reg,
   output logic [DATA_W-1:0]                       rf_in_data,
   input  logic                                    sb_set,
   input  logic [ADDR_W-1:0]                       sb_set_addr,
   input  logic [regfile_pkg::NUM_RD_PORTS-1:0]    rd_en,
   input  logic [regfile_pkg::NUM_RD_PORTS*ADDR_W-1:0] rd_addr,
   output logic                                    hazard,
   output logic [NUM_REGS-1:0]                     busy,
   output logic                                    sb_err
);
   import regfile_pkg::*;

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [ADDR_W-1:0]  reqAddr [NUM_REQ];
   logic [DATA_W-1:0]  reqData [NUM_REQ];
   logic [NUM_REQ-1:0] arbGrant;
   logic [PTR_W-1:0]   grantIdx;
   logic [PTR_W-1:0]   rrPtr;
   logic [PTR_W-1:0]   nextPtr;
   logic               arbAny;
   logic               grantValid;
   logic [ADDR_W-1:0]  winAddr;
   logic [DATA_W-1:0]  winData;
   logic [NUM_REGS-1:0] setHit;
   logic [NUM_REGS-1:0] clrHit;
   logic [NUM_REGS-1:0] busyNext;
   logic               setErr;
   logic               wrErr;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : gUnpack
         assign reqAddr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
         assign reqData[gi] = req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) uArb (
      .reqVec   (req_valid),
      .ptr      (rrPtr),
      .grant    (arbGrant),
      .grantIdx (grantIdx),
      .anyGrant (arbAny),
      .nextPtr  (nextPtr)
   );

   // Nothing is granted while reset is held, so no handshake can complete into a reset flop.
   assign req_ready  = arbGrant & {NUM_REQ{~rst}};
   assign grantValid = arbAny & ~rst;
   assign winAddr    = reqAddr[grantIdx];
   assign winData    = reqData[grantIdx];

`ifdef WB_ARB_FIXED_PRIO_EN
   assign rrPtr = '0;
`else
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         rrPtr <= '0;
      end else if (grantValid) begin
         rrPtr <= nextPtr;
      end
   end
`endif

   // Write port: index/data hold their last value when no grant happens.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         rf_we      <= 1'b0;
         rf_wr_reg  <= '0;
         rf_in_data <= '0;
      end else begin
         rf_we <= grantValid;
         if (grantValid) begin
            rf_wr_reg  <= winAddr;
            rf_in_data <= winData;
         end
      end
   end

   // Per-register next state: a same-cycle reservation overrides the commit clear.
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : gBusy
         assign setHit[gi]   = sb_set && (sb_set_addr == ADDR_W'(gi));
         assign clrHit[gi]   = grantValid && (winAddr == ADDR_W'(gi));
         assign busyNext[gi] = setHit[gi] | (busy[gi] & ~clrHit[gi]);
      end
   endgenerate

   assign setErr = sb_set && busy[sb_set_addr] && !(grantValid && (winAddr == sb_set_addr));
   assign wrErr  = grantValid && !busy[winAddr] && !(sb_set && (sb_set_addr == winAddr));

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         busy   <= '0;
         sb_err <= 1'b0;
      end else begin
         busy   <= busyNext;
         sb_err <= sb_err | setErr | wrErr;
      end
   end

   always_comb begin
      hazard = 1'b0;
      for (int k = 0; k < NUM_RD_PORTS; k++) begin
         if (rd_en[k] && busy[rd_addr[k*ADDR_W +: ADDR_W]]) begin
            hazard = 1'b1;
         end
      end
      if (rst) begin
         hazard = 1'b0;
      end
   end

   grantOneHot: assert property (@(posedge clock) disable iff (rst) $onehot0(req_ready));
   grantNeedsValid: assert property (@(posedge clock) disable iff (rst) (req_ready & ~req_valid) == '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of arbitration, write latency and the scoreboard.
module tb_regfile_wb_arbiter;

   localparam int NR = 3;
   localparam int DW = 16;
   localparam int AW = 4;
   localparam int NG = 16;

   logic            clock = 1'b0;
   logic            rst;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_ready;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_data;
   logic            rf_we;
   logic [AW-1:0]   rf_wr_reg;
   logic [DW-1:0]   rf_in_data;
   logic            sb_set;
   logic [AW-1:0]   sb_set_addr;
   logic [2:0]      rd_en;
   logic [3*AW-1:0] rd_addr;
   logic            hazard;
   logic [NG-1:0]   busy;
   logic            sb_err;

   always #5 clock = ~clock;

   regfile_wb_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NG)) dut (
      .clock(clock), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
      .rf_we(rf_we), .rf_wr_reg(rf_wr_reg), .rf_in_data(rf_in_data),
      .sb_set(sb_set), .sb_set_addr(sb_set_addr), .rd_en(rd_en), .rd_addr(rd_addr),
      .hazard(hazard), .busy(busy), .sb_err(sb_err)
   );

   int nVec = 0;
   int nMis = 0;

   // Model state: who is next in line, which registers are reserved, what the write port shows.
   int          mPtr;
   logic [15:0] mBusy;
   logic        mErr;
   logic        mWe;
   logic [3:0]  mReg;
   logic [15:0] mData;
   int          eGrant;
   logic [2:0]  eReady;
   logic        eHazard;

   task automatic model_reset();
      mPtr = 0; mBusy = '0; mErr = 1'b0; mWe = 1'b0; mReg = '0; mData = '0;
   endtask

   task automatic predict();
      eGrant = -1;
      if (!rst) begin
         for (int k = 0; k < NR; k++) begin
`ifdef WB_ARB_FIXED_PRIO_EN
            int i = k;
`else
            int i = (mPtr + k) % NR;
`endif
            if (eGrant < 0 && req_valid[i]) eGrant = i;
         end
      end
      eReady = (eGrant >= 0) ? 3'(1 << eGrant) : 3'b000;
      eHazard = 1'b0;
      if (!rst) begin
         for (int k = 0; k < 3; k++) begin
            if (rd_en[k] && mBusy[rd_addr[k*AW +: AW]]) eHazard = 1'b1;
         end
      end
   endtask

   task automatic advance();
      logic [15:0] old;
      logic [3:0]  a;
      logic [3:0]  s;
      logic        gv;
      logic        sset;
      logic [15:0] d;
      predict();
      old  = mBusy;
      gv   = (eGrant >= 0);
      a    = gv ? req_addr[eGrant*AW +: AW] : 4'd0;
      d    = gv ? req_data[eGrant*DW +: DW] : 16'd0;
      s    = sb_set_addr;
      sset = sb_set;
      @(posedge clock);
      if (rst) begin
         model_reset();
      end else begin
         if (gv) begin
            if (!old[a] && !(sset && s == a)) mErr = 1'b1;
            mBusy[a] = 1'b0;
            mWe = 1'b1; mReg = a; mData = d;
`ifndef WB_ARB_FIXED_PRIO_EN
            mPtr = (eGrant + 1) % NR;
`endif
         end else begin
            mWe = 1'b0;
         end
         if (sset) begin
            if (old[s] && !(gv && a == s)) mErr = 1'b1;
            mBusy[s] = 1'b1;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0; req_addr = '0; req_data = '0;
      sb_set = 1'b0; sb_set_addr = '0; rd_en = '0; rd_addr = '0;
      repeat (2) @(posedge clock);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      req_valid = 3'b001; req_addr = 12'h006; req_data = 48'h0000_0000_BEEF;
      sb_set = 1'b1; sb_set_addr = 4'd4;
      advance();
      req_valid = 3'b111; sb_set = 1'b0; rd_en = 3'b001; rd_addr = 12'h004;
      #2;
      rst = 1'b1;
      #1;
      nVec++; if (rf_we !== 1'b0) begin nMis++; $display("FAIL reset_we got %b want 0", rf_we); end
      nVec++; if (rf_wr_reg !== 4'd0) begin nMis++; $display("FAIL reset_reg got %0d want 0", rf_wr_reg); end
      nVec++; if (rf_in_data !== 16'h0) begin nMis++; $display("FAIL reset_data got %h want 0000", rf_in_data); end
      nVec++; if (busy !== 16'h0000) begin nMis++; $display("FAIL reset_busy got %h want 0000", busy); end
      nVec++; if (sb_err !== 1'b0) begin nMis++; $display("FAIL reset_err got %b want 0", sb_err); end
      nVec++; if (req_ready !== 3'b000) begin nMis++; $display("FAIL reset_ready got %b want 000", req_ready); end
      nVec++; if (hazard !== 1'b0) begin nMis++; $display("FAIL reset_hazard got %b want 0", hazard); end
      @(posedge clock); #1;
      rst = 1'b0; model_reset();
      req_valid = 3'b001; req_addr = 12'h003; req_data = 48'h0000_0000_1234; rd_en = '0;
      #2;
      nVec++; if (req_ready !== 3'b001) begin nMis++; $display("FAIL first_grant got %b want 001", req_ready); end
      nVec++; if (rf_we !== 1'b0) begin nMis++; $display("FAIL first_pre_we got %b want 0", rf_we); end
      advance();
      req_valid = '0;
      #1;
      nVec++; if (rf_we !== 1'b1) begin nMis++; $display("FAIL first_we got %b want 1", rf_we); end
      nVec++; if (rf_wr_reg !== 4'd3) begin nMis++; $display("FAIL first_reg got %0d want 3", rf_wr_reg); end
      nVec++; if (rf_in_data !== 16'h1234) begin nMis++; $display("FAIL first_data got %h want 1234", rf_in_data); end
      advance();
      nVec++; if (rf_we !== 1'b0 || rf_wr_reg !== 4'd3) begin nMis++; $display("FAIL idle_hold got we=%b reg=%0d want we=0 reg=3", rf_we, rf_wr_reg); end
      $display("txn reset/first write done");
   endtask

   task automatic test_round_robin();
      logic [2:0] want;
      do_reset();
      req_valid = 3'b111;
      for (int c = 0; c < 10; c++) begin
         if (c == 6) req_valid = 3'b101;
         req_addr = 12'($urandom); req_data = 48'({$urandom, $urandom});
         #2;
         predict();
`ifdef WB_ARB_FIXED_PRIO_EN
         want = 3'b001;
`else
         want = (c < 6) ? 3'(1 << (c % 3)) : ((c % 2 == 0) ? 3'b001 : 3'b100);
`endif
         nVec++; if (req_ready !== want) begin nMis++; $display("FAIL rr_seq c=%0d got %b want %b", c, req_ready, want); end
         nVec++; if (req_ready !== eReady) begin nMis++; $display("FAIL rr_model c=%0d got %b want %b", c, req_ready, eReady); end
         if (c > 0) begin
            nVec++;
            if (rf_we !== 1'b1 || rf_wr_reg !== mReg || rf_in_data !== mData) begin
               nMis++; $display("FAIL rr_write c=%0d got %b/%0d/%h want 1/%0d/%h", c, rf_we, rf_wr_reg, rf_in_data, mReg, mData);
            end
         end
         $display("txn rr c=%0d ready=%b", c, req_ready);
         advance();
      end
      req_valid = '0;
   endtask

   task automatic test_scoreboard();
      logic [15:0] d;
      do_reset();
      d = 16'($urandom);
      sb_set = 1'b1; sb_set_addr = 4'd5; rd_en = 3'b001; rd_addr = 12'h005;
      #2;
      nVec++; if (hazard !== 1'b0) begin nMis++; $display("FAIL sb_pre_hazard got %b want 0", hazard); end
      advance();
      sb_set = 1'b0;
      #1;
      nVec++; if (hazard !== 1'b1) begin nMis++; $display("FAIL sb_hazard got %b want 1", hazard); end
      nVec++; if (busy !== 16'h0020) begin nMis++; $display("FAIL sb_busy got %h want 0020", busy); end
      req_valid = 3'b010; req_addr = 12'h050; req_data = {16'h0, d, 16'h0};
      #1;
      nVec++; if (req_ready !== 3'b010 || hazard !== 1'b1) begin nMis++; $display("FAIL sb_grant got %b/%b want 010/1", req_ready, hazard); end
      advance();
      req_valid = '0;
      #1;
      nVec++; if (busy !== 16'h0000 || hazard !== 1'b0) begin nMis++; $display("FAIL sb_clear got %h/%b want 0000/0", busy, hazard); end
      nVec++; if (rf_we !== 1'b1 || rf_wr_reg !== 4'd5 || rf_in_data !== d) begin nMis++; $display("FAIL sb_write got %b/%0d/%h want 1/5/%h", rf_we, rf_wr_reg, rf_in_data, d); end
      nVec++; if (sb_err !== 1'b0) begin nMis++; $display("FAIL sb_noerr got %b want 0", sb_err); end
      $display("txn scoreboard R5 done");
   endtask

   task automatic test_set_clear();
      do_reset();
      sb_set = 1'b1; sb_set_addr = 4'd7;
      advance();
      req_valid = 3'b001; req_addr = 12'h007; req_data = 48'h0000_0000_7777;
      advance();
      req_valid = '0; sb_set = 1'b0;
      #1;
      nVec++; if (busy[7] !== 1'b1) begin nMis++; $display("FAIL setclr_busy got %b want 1", busy[7]); end
      nVec++; if (sb_err !== 1'b0) begin nMis++; $display("FAIL setclr_err got %b want 0", sb_err); end
      nVec++; if (rf_we !== 1'b1 || rf_wr_reg !== 4'd7) begin nMis++; $display("FAIL setclr_write got %b/%0d want 1/7", rf_we, rf_wr_reg); end
      $display("txn set/clear R7 done");
   endtask

   task automatic test_errors();
      do_reset();
      sb_set = 1'b1; sb_set_addr = 4'd2;
      advance();
      #1;
      nVec++; if (sb_err !== 1'b0) begin nMis++; $display("FAIL err_first got %b want 0", sb_err); end
      advance();
      sb_set = 1'b0;
      repeat (3) advance();
      nVec++; if (sb_err !== 1'b1) begin nMis++; $display("FAIL err_sticky got %b want 1", sb_err); end
      do_reset();
      #1;
      nVec++; if (sb_err !== 1'b0) begin nMis++; $display("FAIL err_cleared got %b want 0", sb_err); end
      req_valid = 3'b001; req_addr = 12'h009; req_data = 48'h0000_0000_0909;
      advance();
      req_valid = '0;
      #1;
      nVec++; if (rf_we !== 1'b1 || rf_wr_reg !== 4'd9 || rf_in_data !== 16'h0909) begin nMis++; $display("FAIL err_wr got %b/%0d/%h want 1/9/0909", rf_we, rf_wr_reg, rf_in_data); end
      nVec++; if (sb_err !== 1'b1) begin nMis++; $display("FAIL err_wr_flag got %b want 1", sb_err); end
      $display("txn error cases done");
   endtask

   task automatic test_reset_mid();
      do_reset();
      sb_set = 1'b1; sb_set_addr = 4'd13;
      advance();
      sb_set = 1'b0;
      req_valid = 3'b100; req_addr = {4'd13, 8'h00}; req_data = {16'h00FF, 32'h0};
      #2;
      nVec++; if (req_ready !== 3'b100) begin nMis++; $display("FAIL mid_grant got %b want 100", req_ready); end
      rst = 1'b1;
      #1;
      nVec++; if (req_ready !== 3'b000 || busy !== 16'h0) begin nMis++; $display("FAIL mid_async got %b/%h want 000/0000", req_ready, busy); end
      @(posedge clock); #1;
      nVec++; if (rf_we !== 1'b0 || rf_wr_reg !== 4'd0 || rf_in_data !== 16'h0) begin nMis++; $display("FAIL mid_discard got %b/%0d/%h want 0/0/0000", rf_we, rf_wr_reg, rf_in_data); end
      rst = 1'b0; req_valid = '0; model_reset();
      advance();
      nVec++; if (rf_we !== 1'b0 || busy !== 16'h0) begin nMis++; $display("FAIL mid_after got %b/%h want 0/0000", rf_we, busy); end
      $display("txn reset mid-operation done");
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 300; c++) begin
         req_valid   = 3'($urandom);
         req_addr    = 12'($urandom);
         req_data    = 48'({$urandom, $urandom});
         sb_set      = ($urandom_range(0, 2) == 0);
         sb_set_addr = 4'($urandom);
         rd_en       = 3'($urandom);
         rd_addr     = 12'($urandom);
         #2;
         predict();
         nVec++; if (req_ready !== eReady) begin nMis++; $display("FAIL rnd_ready c=%0d got %b want %b", c, req_ready, eReady); end
         nVec++; if (hazard !== eHazard) begin nMis++; $display("FAIL rnd_hazard c=%0d got %b want %b", c, hazard, eHazard); end
         nVec++; if (busy !== mBusy) begin nMis++; $display("FAIL rnd_busy c=%0d got %h want %h", c, busy, mBusy); end
         nVec++; if (sb_err !== mErr) begin nMis++; $display("FAIL rnd_err c=%0d got %b want %b", c, sb_err, mErr); end
         nVec++;
         if (rf_we !== mWe || rf_wr_reg !== mReg || rf_in_data !== mData) begin
            nMis++; $display("FAIL rnd_write c=%0d got %b/%0d/%h want %b/%0d/%h", c, rf_we, rf_wr_reg, rf_in_data, mWe, mReg, mData);
         end
         $display("txn rnd c=%0d ready=%b we=%b reg=%0d data=%h", c, req_ready, rf_we, rf_wr_reg, rf_in_data);
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_scoreboard();
      test_set_clear();
      test_errors();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
